mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Parametrised multicycle control unit for the 32-bit MIPS datapath; it is the successor of the fixed-latency control_unit.
- Adds a variable-latency memory handshake (mem_req/mem_ready) with a timeout watchdog.
- Adds an illegal-instruction trap, a sticky fault code and a retired-instruction counter.
- Drives the existing datapath mux selects and enables unchanged, so it drops into the core in place of control_unit.

Parameters:
- ALU_OP_WIDTH, 4, width of ALUControl; encodings come from the codebase ALU op defines.
- WAIT_TIMEOUT, 255, maximum consecutive stalled cycles per memory access before fault; legal range 1..2^TMO_W-1.
- TMO_W, 8, width of the wait counter.
- RET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- Opcode  in  6  Instr[31:26].
- Funct  in  6  Instr[5:0].
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested.
- IorD  out  1  address select: 0=PC, 1=ALUOut.
- ALUSrcA  out  2  00=PC, 10=A, 11=B.
- ALUSrcB  out  3  000=B, 001=4, 010=SignImm, 011=Shamt, 100=SignImm<<2.
- PCSrc  out  2  00=ALUResult, 01=ALUOut, 11=jump target.
- RegDst  out  2  00=rt, 01=rd, 10=r31.
- MemtoReg  out  2  00=ALUOut, 01=Data, 10=PC.
- Branch  out  2  01=beq, 10=bne, 00=none.
- IRWrite, MemWrite, PCWrite, RegWrite  out  1 each  enables.
- ALUControl  out  ALU_OP_WIDTH  ALU operation.
- fault  out  1  sticky fault flag.
- fault_code  out  2  01=memory timeout, 10=illegal instruction.
- retired  out  RET_W  count of instructions completed.

Behaviour:
- Moore-style outputs decoded from registered state. Exception: the IRWrite, PCWrite and MemWrite strobes in the wait states are additionally qualified by mem_ready.
- Every output not listed for a state is 0. Default ALUControl is ADD.
- Reset (asynchronous, any time, including mid-access):
  - state=FETCH, wait counter=0, fault=0, fault_code=00, retired=0.
  - All strobes drop combinationally with the reset state.
- FETCH:
  - Outputs: mem_req=1, IorD=0, ALUSrcA=00, ALUSrcB=001, ADD, PCSrc=00.
  - When mem_ready=1: IRWrite=1, PCWrite=1, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=00, ALUSrcB=100, ADD (branch target into ALUOut). Next state by opcode:
  - lw/sw -> MEMADR
  - R-type -> EXEC_R
  - addi/andi/ori/slti -> EXEC_I
  - beq/bne -> BRANCH
  - j -> JUMP
  - jal -> JAL
  - anything else -> FAULT with code 10.
- MEMADR: ALUSrcA=10, ALUSrcB=010, ADD. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, IorD=1. On mem_ready go to MEMWB.
- MEMWB: RegDst=00, MemtoReg=01, RegWrite=1, then retire.
- MEMWR: mem_req=1, IorD=1, MemWrite=mem_ready. On mem_ready, retire.
- EXEC_R:
  - Funct add/sub/and/or/slt: ALUSrcA=10, ALUSrcB=000, op per funct.
  - Funct sll/srl: ALUSrcA=11, ALUSrcB=011, op SLL/SRL.
  - Any other funct goes to FAULT with code 10, with no register write.
- ALUWB: RegDst=01, MemtoReg=00, RegWrite=1, then retire.
- EXEC_I: ALUSrcA=10, ALUSrcB=010, op per opcode (SignImm for all immediates). Then IWB.
- IWB: RegDst=00, MemtoReg=00, RegWrite=1, then retire.
- BRANCH: ALUSrcA=10, ALUSrcB=000, SUB, PCSrc=01, Branch=01/10. Retire regardless of outcome.
- JUMP: PCSrc=11, PCWrite=1, then retire.
- JAL: PCSrc=11, PCWrite=1, RegDst=10, MemtoReg=10, RegWrite=1 (PC already holds PC+4), then retire.
- Retire: retired += 1 (wraps modulo 2^RET_W); next state FETCH.
- Wait counter:
  - Cleared on entering any mem_req state and on every mem_ready.
  - Increments each cycle with mem_req=1 and mem_ready=0.
  - When the counter equals WAIT_TIMEOUT-1 and mem_ready=0, next state is FAULT with code 01.
  - mem_ready in that same cycle wins; no fault.
- FAULT:
  - Absorbing until rst. All strobes 0, mem_req=0, fault=1.
  - fault_code is held at the first cause.
- Cycle counts with zero wait: lw 5, sw 4, R 4, I 4, beq/bne 3, j/jal 3. Each stalled cycle adds 1.

Test Plan:
- Zero-wait program (addi r1,r0,5; sll r2,r1,2; sw r2,0(r0); lw r3,0(r0); beq r3,r2,+1) -> r3=20, branch taken, retired=5 after 4+4+4+5+3=20 cycles.
- lw with mem_ready held low 3 cycles in FETCH and 2 in MEMRD -> IRWrite/PCWrite pulse once on the ready cycle; RegWrite once; total 10 cycles.
- WAIT_TIMEOUT=4, mem_ready stuck 0 in FETCH -> fault=1, fault_code=01 after 4 cycles; no strobes afterwards; mem_ready arriving in the 4th cycle -> no fault.
- Opcode 6'h3F, and separately R-type funct 6'h3F -> FAULT, code 10, RegWrite never asserted, retired unchanged.
- jal from PC=0x40 with index 0x10 -> PC=0x40, r31=0x44 written in the same cycle, retired+1.
- rst asserted during MEMWR stall, then released -> MemWrite never pulses, state FETCH, retired=0, fault=0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS control FSM with memory handshake, watchdog, trap and retire counter
module mc_control_fsm #(
    parameter int ALU_OP_WIDTH = 4,
    parameter int WAIT_TIMEOUT = 255,
    parameter int TMO_W        = 8,
    parameter int RET_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              Opcode,
    input  logic [5:0]              Funct,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    IorD,
    output logic [1:0]              ALUSrcA,
    output logic [2:0]              ALUSrcB,
    output logic [1:0]              PCSrc,
    output logic [1:0]              RegDst,
    output logic [1:0]              MemtoReg,
    output logic [1:0]              Branch,
    output logic                    IRWrite,
    output logic                    MemWrite,
    output logic                    PCWrite,
    output logic                    RegWrite,
    output logic [ALU_OP_WIDTH-1:0] ALUControl,
    output logic                    fault,
    output logic [1:0]              fault_code,
    output logic [RET_W-1:0]        retired
);

    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = ALU_OP_WIDTH'(9);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
        S_ALUWB, S_EXEC_I, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_FAULT
    } state_t;

    state_t           state, next_state;
    logic [TMO_W-1:0] wait_cnt;
    logic [1:0]       fault_code_q, next_code;
    logic [RET_W-1:0] retired_q;
    logic             req, ir_w, pc_w, mem_w, reg_w, retire;
    logic             stall_expired;

    assign stall_expired = !mem_ready && (wait_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_FETCH;
            wait_cnt     <= '0;
            fault_code_q <= 2'b00;
            retired_q    <= '0;
        end else begin
            state <= next_state;
            // Every memory state is entered with the counter already at zero,
            // since it only counts while a request is outstanding.
            if (!req || mem_ready)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + TMO_W'(1);
            if (state != S_FAULT && next_state == S_FAULT)
                fault_code_q <= next_code;
            if (retire)
                retired_q <= retired_q + RET_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        next_code  = fault_code_q;
        retire     = 1'b0;
        req        = 1'b0;
        ir_w       = 1'b0;
        pc_w       = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        IorD       = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 3'b000;
        PCSrc      = 2'b00;
        RegDst     = 2'b00;
        MemtoReg   = 2'b00;
        Branch     = 2'b00;
        ALUControl = ALU_ADD;
        case (state)
            S_FETCH: begin
                req     = 1'b1;
                ALUSrcB = 3'b001;
                if (mem_ready) begin
                    ir_w       = 1'b1;
                    pc_w       = 1'b1;
                    next_state = S_DECODE;
                end else if (stall_expired) begin
                    next_state = S_FAULT;
                    next_code  = 2'b01;
                end
            end
            S_DECODE: begin
                ALUSrcB = 3'b100;
                case (Opcode)
                    OP_LW, OP_SW:                      next_state = S_MEMADR;
                    OP_RTYPE:                          next_state = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_EXEC_I;
                    OP_BEQ, OP_BNE:                    next_state = S_BRANCH;
                    OP_J:                              next_state = S_JUMP;
                    OP_JAL:                            next_state = S_JAL;
                    default: begin
                        next_state = S_FAULT;
                        next_code  = 2'b10;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 3'b010;
                next_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                req  = 1'b1;
                IorD = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end else if (stall_expired) begin
                    next_state = S_FAULT;
                    next_code  = 2'b01;
                end
            end
            S_MEMWB: begin
                MemtoReg   = 2'b01;
                reg_w      = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                req   = 1'b1;
                IorD  = 1'b1;
                mem_w = mem_ready;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if (stall_expired) begin
                    next_state = S_FAULT;
                    next_code  = 2'b01;
                end
            end
            S_EXEC_R: begin
                next_state = S_ALUWB;
                ALUSrcA    = 2'b10;
                case (Funct)
                    FN_ADD: ALUControl = ALU_ADD;
                    FN_SUB: ALUControl = ALU_SUB;
                    FN_AND: ALUControl = ALU_AND;
                    FN_OR:  ALUControl = ALU_OR;
                    FN_SLT: ALUControl = ALU_SLT;
                    FN_SLL, FN_SRL: begin
                        ALUSrcA    = 2'b11;
                        ALUSrcB    = 3'b011;
                        ALUControl = (Funct == FN_SLL) ? ALU_SLL : ALU_SRL;
                    end
                    default: begin
                        ALUSrcA    = 2'b00;
                        next_state = S_FAULT;
                        next_code  = 2'b10;
                    end
                endcase
            end
            S_ALUWB: begin
                RegDst     = 2'b01;
                reg_w      = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 3'b010;
                next_state = S_IWB;
                case (Opcode)
                    OP_ANDI: ALUControl = ALU_AND;
                    OP_ORI:  ALUControl = ALU_OR;
                    OP_SLTI: ALUControl = ALU_SLT;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            S_IWB: begin
                reg_w      = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                Branch     = (Opcode == OP_BNE) ? 2'b10 : 2'b01;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = 2'b11;
                pc_w       = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                PCSrc      = 2'b11;
                pc_w       = 1'b1;
                RegDst     = 2'b10;
                MemtoReg   = 2'b10;
                reg_w      = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_FETCH;
        endcase
    end

    // Reset must silence the strobes immediately, even though FETCH decodes mem_ready.
    assign mem_req    = req   & ~rst;
    assign IRWrite    = ir_w  & ~rst;
    assign PCWrite    = pc_w  & ~rst;
    assign MemWrite   = mem_w & ~rst;
    assign RegWrite   = reg_w & ~rst;
    assign fault      = (state == S_FAULT);
    assign fault_code = fault_code_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - self-checking bench: control FSM driving a behavioural MIPS datapath
module tb_mc_control_fsm;

    localparam int RET_W = 32;
    localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_ADD = 4'd2, A_SUB = 4'd6;
    localparam logic [3:0] A_SLT = 4'd7, A_SLL = 4'd8, A_SRL = 4'd9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_ready = 1'b0;
    logic [5:0] Opcode, Funct;
    logic mem_req, IorD, IRWrite, MemWrite, PCWrite, RegWrite, fault;
    logic [1:0] ALUSrcA, PCSrc, RegDst, MemtoReg, Branch, fault_code;
    logic [2:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic [RET_W-1:0] retired;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.ALU_OP_WIDTH(4), .WAIT_TIMEOUT(4), .TMO_W(8), .RET_W(RET_W)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .Branch(Branch), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUControl(ALUControl),
        .fault(fault), .fault_code(fault_code), .retired(retired)
    );

    // Behavioural datapath; the memory latches its address when a request first stalls.
    logic [31:0] imem [0:255];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_dmem [0:63];
    logic [31:0] m_pc, m_ir, m_a, m_b, m_aluout, m_mdr, m_lat_addr, pc_init;
    logic        m_busy;
    logic [31:0] simm, srca, srcb, alu_y, addr_raw, eff, rdata, wd, pc_next;
    logic [4:0]  dst;
    logic        pc_en;

    assign Opcode = m_ir[31:26];
    assign Funct  = m_ir[5:0];

    always_comb begin
        simm = {{16{m_ir[15]}}, m_ir[15:0]};
        case (ALUSrcA)
            2'b10:   srca = m_a;
            2'b11:   srca = m_b;
            default: srca = m_pc;
        endcase
        case (ALUSrcB)
            3'b001:  srcb = 32'd4;
            3'b010:  srcb = simm;
            3'b011:  srcb = {27'd0, m_ir[10:6]};
            3'b100:  srcb = simm << 2;
            default: srcb = m_b;
        endcase
        case (ALUControl)
            A_AND:   alu_y = srca & srcb;
            A_OR:    alu_y = srca | srcb;
            A_SUB:   alu_y = srca - srcb;
            A_SLT:   alu_y = ($signed(srca) < $signed(srcb)) ? 32'd1 : 32'd0;
            A_SLL:   alu_y = srca << srcb[4:0];
            A_SRL:   alu_y = srca >> srcb[4:0];
            default: alu_y = srca + srcb;
        endcase
        addr_raw = IorD ? m_aluout : m_pc;
        eff      = m_busy ? m_lat_addr : addr_raw;
        rdata    = IorD ? m_dmem[eff[7:2]] : imem[eff[9:2]];
        case (RegDst)
            2'b01:   dst = m_ir[15:11];
            2'b10:   dst = 5'd31;
            default: dst = m_ir[20:16];
        endcase
        case (MemtoReg)
            2'b01:   wd = m_mdr;
            2'b10:   wd = m_pc;
            default: wd = m_aluout;
        endcase
        case (PCSrc)
            2'b01:   pc_next = m_aluout;
            2'b11:   pc_next = {m_pc[31:28], m_ir[25:0], 2'b00};
            default: pc_next = alu_y;
        endcase
        pc_en = PCWrite || (Branch == 2'b01 && alu_y == 32'd0) || (Branch == 2'b10 && alu_y != 32'd0);
    end

    always @(posedge clk) begin
        if (rst) begin
            m_pc <= pc_init; m_ir <= '0; m_a <= '0; m_b <= '0; m_aluout <= '0; m_mdr <= '0;
            m_busy <= 1'b0; m_lat_addr <= '0;
            for (int i = 0; i < 32; i++) m_regs[i] <= '0;
            for (int i = 0; i < 64; i++) m_dmem[i] <= '0;
        end else begin
            if (IRWrite) m_ir <= rdata;
            m_mdr    <= rdata;
            m_a      <= m_regs[m_ir[25:21]];
            m_b      <= m_regs[m_ir[20:16]];
            m_aluout <= alu_y;
            if (pc_en) m_pc <= pc_next;
            if (RegWrite && dst != 5'd0) m_regs[dst] <= wd;
            if (MemWrite) m_dmem[eff[7:2]] <= m_b;
            if (mem_req && !mem_ready) begin
                if (!m_busy) m_lat_addr <= addr_raw;
                m_busy <= 1'b1;
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    // ISA-level reference state
    logic [31:0] exp_r [0:31];
    logic [31:0] exp_m [0:63];
    logic [31:0] exp_pc;

    task automatic do_reset(input logic [31:0] pc0);
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b0; pc_init = pc0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_pc = pc0;
        for (int i = 0; i < 32; i++) exp_r[i] = '0;
        for (int i = 0; i < 64; i++) exp_m[i] = '0;
    endtask

    // Runs one instruction from FETCH; fs/ms are stall cycles for fetch and data access.
    task automatic run_instr(input int fs_in, input int ms_in, output int cyc, output int n_ir,
                             output int n_pc, output int n_rw, output int n_mw, output int n_both);
        int fs, ms;
        logic [RET_W-1:0] r0;
        bit done;
        fs = fs_in; ms = ms_in; r0 = retired; done = 0;
        cyc = 0; n_ir = 0; n_pc = 0; n_rw = 0; n_mw = 0; n_both = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (mem_req && !IorD) begin
                if (fs > 0) begin mem_ready = 1'b0; fs--; end else mem_ready = 1'b1;
            end else if (mem_req) begin
                if (ms > 0) begin mem_ready = 1'b0; ms--; end else mem_ready = 1'b1;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            n_ir += int'(IRWrite); n_pc += int'(PCWrite);
            n_rw += int'(RegWrite); n_mw += int'(MemWrite);
            n_both += int'(RegWrite && PCWrite);
            cyc++;
            @(posedge clk);
            #1;
            if (retired !== r0 || fault) done = 1;
        end
    endtask

    // Applies the instruction's architectural effect and returns expected timing/strobe counts.
    task automatic exec_expect(input logic [31:0] ins, output int base, output int wr,
                               output int mw, output int pcw, output bit memop);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        logic [31:0] s, npc, res;
        op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16];
        rd = ins[15:11]; sh = ins[10:6]; s = {{16{ins[15]}}, ins[15:0]};
        npc = exp_pc + 32'd4; base = 4; wr = 0; mw = 0; pcw = 1; memop = 0; res = '0;
        case (op)
            6'h00: begin
                wr = 1;
                case (fn)
                    6'h20: res = exp_r[rs] + exp_r[rt];
                    6'h22: res = exp_r[rs] - exp_r[rt];
                    6'h24: res = exp_r[rs] & exp_r[rt];
                    6'h25: res = exp_r[rs] | exp_r[rt];
                    6'h2A: res = {31'd0, $signed(exp_r[rs]) < $signed(exp_r[rt])};
                    6'h00: res = exp_r[rt] << sh;
                    default: res = exp_r[rt] >> sh;
                endcase
                if (rd != 0) exp_r[rd] = res;
            end
            6'h08, 6'h0C, 6'h0D, 6'h0A: begin
                wr = 1;
                if (op == 6'h08) res = exp_r[rs] + s;
                else if (op == 6'h0C) res = exp_r[rs] & s;
                else if (op == 6'h0D) res = exp_r[rs] | s;
                else res = {31'd0, $signed(exp_r[rs]) < $signed(s)};
                if (rt != 0) exp_r[rt] = res;
            end
            6'h23: begin
                base = 5; wr = 1; memop = 1;
                if (rt != 0) exp_r[rt] = exp_m[s[7:2]];
            end
            6'h2B: begin
                mw = 1; memop = 1;
                exp_m[s[7:2]] = exp_r[rt];
            end
            6'h04, 6'h05: begin
                base = 3;
                if ((exp_r[rs] == exp_r[rt]) == (op == 6'h04)) npc = npc + (s << 2);
            end
            default: begin
                base = 3; pcw = 2;
                if (op == 6'h03) begin wr = 1; exp_r[31] = npc; end
                npc = {npc[31:28], ins[25:0], 2'b00};
            end
        endcase
        exp_pc = npc;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1;
        #1;
        checks++;
        if ({IRWrite, PCWrite, MemWrite, RegWrite} !== 4'b0000) begin
            failures++; $display("FAIL reset_strobes got=%b want=0000", {IRWrite, PCWrite, MemWrite, RegWrite});
        end
        checks++;
        if (fault !== 1'b0 || fault_code !== 2'b00 || retired !== '0) begin
            failures++; $display("FAIL reset_state fault=%b code=%b retired=%0d want 0/00/0", fault, fault_code, retired);
        end
        do_reset(32'h0);
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1 || IorD !== 1'b0 || ALUSrcB !== 3'b001 || ALUControl !== A_ADD || IRWrite !== 1'b0) begin
            failures++; $display("FAIL reset_fetch req=%b iord=%b srcb=%b op=%h irw=%b want 1/0/001/2/0",
                                 mem_req, IorD, ALUSrcB, ALUControl, IRWrite);
        end
    endtask

    task automatic test_program;
        int cyc, tot, a, b, c, d, e;
        logic [31:0] prog [0:4];
        prog[0] = {6'h08, 5'd0, 5'd1, 16'd5};
        prog[1] = {6'h00, 5'd0, 5'd1, 5'd2, 5'd2, 6'h00};
        prog[2] = {6'h2B, 5'd0, 5'd2, 16'd0};
        prog[3] = {6'h23, 5'd0, 5'd3, 16'd0};
        prog[4] = {6'h04, 5'd3, 5'd2, 16'd1};
        for (int i = 0; i < 5; i++) imem[i] = prog[i];
        do_reset(32'h0);
        tot = 0;
        for (int i = 0; i < 5; i++) begin
            run_instr(0, 0, cyc, a, b, c, d, e);
            tot += cyc;
        end
        checks++;
        if (tot != 20) begin failures++; $display("FAIL prog_cycles got=%0d want=20", tot); end
        checks++;
        if (m_regs[3] !== 32'd20) begin failures++; $display("FAIL prog_r3 got=%0d want=20", m_regs[3]); end
        checks++;
        if (m_pc !== 32'h18) begin failures++; $display("FAIL prog_branch_pc got=%h want=00000018", m_pc); end
        checks++;
        if (retired !== 32'd5) begin failures++; $display("FAIL prog_retired got=%0d want=5", retired); end
    endtask

    task automatic test_lw_stall;
        int cyc, n_ir, n_pc, n_rw, n_mw, n_both;
        imem[6] = {6'h23, 5'd0, 5'd4, 16'd0};
        run_instr(3, 2, cyc, n_ir, n_pc, n_rw, n_mw, n_both);
        checks++;
        if (cyc != 10) begin failures++; $display("FAIL lw_stall_cycles got=%0d want=10", cyc); end
        checks++;
        if (n_ir != 1 || n_pc != 1 || n_rw != 1 || n_mw != 0) begin
            failures++; $display("FAIL lw_stall_strobes ir=%0d pc=%0d rw=%0d mw=%0d want 1/1/1/0", n_ir, n_pc, n_rw, n_mw);
        end
        checks++;
        if (m_regs[4] !== 32'd20) begin failures++; $display("FAIL lw_stall_data got=%0d want=20", m_regs[4]); end
    endtask

    task automatic test_timeout;
        int cyc, n_ir, n_pc, n_rw, n_mw, n_both, bad;
        imem[0] = {6'h08, 5'd0, 5'd1, 16'd5};
        do_reset(32'h0);
        run_instr(100, 0, cyc, n_ir, n_pc, n_rw, n_mw, n_both);
        checks++;
        if (cyc != 4 || fault !== 1'b1 || fault_code !== 2'b01) begin
            failures++; $display("FAIL timeout_fetch cyc=%0d fault=%b code=%b want 4/1/01", cyc, fault, fault_code);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (mem_req || IRWrite || PCWrite || MemWrite || RegWrite || !fault || fault_code !== 2'b01) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL fault_absorbing bad_cycles=%0d want=0", bad); end
        do_reset(32'h0);
        run_instr(3, 0, cyc, n_ir, n_pc, n_rw, n_mw, n_both);
        checks++;
        if (cyc != 7 || fault !== 1'b0 || m_regs[1] !== 32'd5) begin
            failures++; $display("FAIL timeout_edge cyc=%0d fault=%b r1=%0d want 7/0/5", cyc, fault, m_regs[1]);
        end
    endtask

    task automatic test_illegal;
        int cyc, n_ir, n_pc, n_rw, n_mw, n_both;
        imem[0] = {6'h08, 5'd0, 5'd1, 16'd5};
        imem[1] = 32'hFC00_0000;
        do_reset(32'h0);
        run_instr(0, 0, cyc, n_ir, n_pc, n_rw, n_mw, n_both);
        run_instr(0, 0, cyc, n_ir, n_pc, n_rw, n_mw, n_both);
        checks++;
        if (cyc != 2 || fault !== 1'b1 || fault_code !== 2'b10 || n_rw != 0 || retired !== 32'd1) begin
            failures++; $display("FAIL illegal_opcode cyc=%0d fault=%b code=%b rw=%0d ret=%0d want 2/1/10/0/1",
                                 cyc, fault, fault_code, n_rw, retired);
        end
        imem[0] = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3F};
        do_reset(32'h0);
        run_instr(0, 0, cyc, n_ir, n_pc, n_rw, n_mw, n_both);
        checks++;
        if (cyc != 3 || fault !== 1'b1 || fault_code !== 2'b10 || n_rw != 0 || retired !== 32'd0) begin
            failures++; $display("FAIL illegal_funct cyc=%0d fault=%b code=%b rw=%0d ret=%0d want 3/1/10/0/0",
                                 cyc, fault, fault_code, n_rw, retired);
        end
    endtask

    task automatic test_jal;
        int cyc, n_ir, n_pc, n_rw, n_mw, n_both;
        imem[16] = {6'h03, 26'h10};
        do_reset(32'h40);
        run_instr(0, 0, cyc, n_ir, n_pc, n_rw, n_mw, n_both);
        checks++;
        if (cyc != 3 || m_pc !== 32'h40 || m_regs[31] !== 32'h44) begin
            failures++; $display("FAIL jal_result cyc=%0d pc=%h r31=%h want 3/00000040/00000044", cyc, m_pc, m_regs[31]);
        end
        checks++;
        if (n_both != 1 || n_rw != 1 || retired !== 32'd1) begin
            failures++; $display("FAIL jal_strobes both=%0d rw=%0d ret=%0d want 1/1/1", n_both, n_rw, retired);
        end
    endtask

    task automatic test_reset_mid;
        int cyc, n_ir, n_pc, n_rw, n_mw, n_both, mw_seen;
        imem[0] = {6'h08, 5'd0, 5'd1, 16'd7};
        imem[1] = {6'h2B, 5'd0, 5'd1, 16'd8};
        do_reset(32'h0);
        run_instr(0, 0, cyc, n_ir, n_pc, n_rw, n_mw, n_both);
        mw_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_ready = mem_req && !IorD;
            #1 mw_seen += int'(MemWrite);
        end
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1;
        #1 mw_seen += int'(MemWrite);
        @(posedge clk);
        #1 rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (mw_seen != 0) begin failures++; $display("FAIL rst_mid_memwrite pulses=%0d want=0", mw_seen); end
        checks++;
        if (retired !== '0 || fault !== 1'b0 || mem_req !== 1'b1 || IorD !== 1'b0 || ALUSrcB !== 3'b001) begin
            failures++; $display("FAIL rst_mid_state ret=%0d fault=%b req=%b iord=%b srcb=%b want 0/0/1/0/001",
                                 retired, fault, mem_req, IorD, ALUSrcB);
        end
    endtask

    task automatic test_random;
        int cyc, n_ir, n_pc, n_rw, n_mw, n_both, base, wr, mw, pcw, fs, ms, kind, bad;
        bit memop;
        logic [31:0] ins;
        logic [4:0] rs, rt, rd;
        logic [5:0] ftab [0:4];
        logic [5:0] itab [0:3];
        ftab[0] = 6'h20; ftab[1] = 6'h22; ftab[2] = 6'h24; ftab[3] = 6'h25; ftab[4] = 6'h2A;
        itab[0] = 6'h08; itab[1] = 6'h0C; itab[2] = 6'h0D; itab[3] = 6'h0A;
        do_reset(32'h0);
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 7);
            rs = 5'($urandom_range(1, 7)); rt = 5'($urandom_range(1, 7)); rd = 5'($urandom_range(1, 7));
            case (kind)
                0: ins = {6'h00, rs, rt, rd, 5'd0, ftab[$urandom_range(0, 4)]};
                1: ins = {6'h00, 5'd0, rt, rd, 5'($urandom_range(0, 31)), ($urandom_range(0, 1) != 0) ? 6'h02 : 6'h00};
                2: ins = {itab[$urandom_range(0, 3)], rs, rt, 16'($urandom)};
                3: ins = {6'h23, 5'd0, rt, 16'($urandom_range(0, 63) * 4)};
                4: ins = {6'h2B, 5'd0, rt, 16'($urandom_range(0, 63) * 4)};
                5: ins = {($urandom_range(0, 1) != 0) ? 6'h05 : 6'h04, rs, rt, 16'($urandom_range(0, 8) - 4)};
                6: ins = {6'h02, 26'($urandom_range(0, 255))};
                default: ins = {6'h03, 26'($urandom_range(0, 255))};
            endcase
            imem[exp_pc[9:2]] = ins;
            exec_expect(ins, base, wr, mw, pcw, memop);
            fs = $urandom_range(0, 3); ms = $urandom_range(0, 3);
            run_instr(fs, ms, cyc, n_ir, n_pc, n_rw, n_mw, n_both);
            checks++;
            if (cyc != base + fs + (memop ? ms : 0)) begin
                failures++; $display("FAIL rnd_cycles ins=%h got=%0d want=%0d", ins, cyc, base + fs + (memop ? ms : 0));
            end
            checks++;
            if (n_ir != 1 || n_rw != wr || n_mw != mw || n_pc != pcw || fault !== 1'b0) begin
                failures++; $display("FAIL rnd_strobes ins=%h ir=%0d rw=%0d mw=%0d pc=%0d fault=%b want 1/%0d/%0d/%0d/0",
                                     ins, n_ir, n_rw, n_mw, n_pc, fault, wr, mw, pcw);
            end
            checks++;
            if (m_pc !== exp_pc || retired !== RET_W'(n + 1)) begin
                failures++; $display("FAIL rnd_pc_retired ins=%h pc=%h ret=%0d want %h/%0d", ins, m_pc, retired, exp_pc, n + 1);
            end
            bad = 0;
            for (int i = 0; i < 32; i++) if (m_regs[i] !== exp_r[i]) bad++;
            for (int i = 0; i < 64; i++) if (m_dmem[i] !== exp_m[i]) bad++;
            checks++;
            if (bad != 0) begin failures++; $display("FAIL rnd_arch_state ins=%h mismatched_words=%0d want=0", ins, bad); end
        end
    endtask

    initial begin
        pc_init = '0;
        for (int i = 0; i < 256; i++) imem[i] = '0;
        test_reset();
        test_program();
        test_lw_stall();
        test_timeout();
        test_illegal();
        test_jal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
